// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler
//   Shares one 4-bit adder slice between two requesters. Each request is a
//   WIDTH-bit add or subtract. Requests are granted round-robin and their
//   operands latched. The sum is then built one nibble per cycle, LSB first,
//   with a carry register between nibbles. The result is returned as a
//   one-cycle tagged strobe.
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   reqN_valid/ready      : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b        : operands
//   reqN_sub              : 1 = A-B, 0 = A+B
//   rsp_valid             : one-cycle result strobe
//   rsp_id                : index of the requester that owns the result
//   rsp_sum, rsp_cout     : result and final carry (for sub, 1 = no borrow)
//   busy                  : an operation is in flight
module nibble_add_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_id_q, rsp_id_d;

  logic             grant0, grant1, sel_sub;
  logic [4:0]       nib_sum;

  // Under contention the requester that did not win last time is granted.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_id     = rsp_id_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    work_d       = work_q;
    id_d         = id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;
    sel_sub      = 1'b0;
    nib_sum      = 5'd0;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          sel_sub      = grant1 ? req1_sub : req0_sub;
          a_d          = grant1 ? req1_a : req0_a;
          // Subtract as A + ~B + 1: invert B here, the +1 enters as carry-in.
          b_d          = (grant1 ? req1_b : req0_b) ^ {WIDTH{sel_sub}};
          carry_d      = sel_sub;
          id_d         = grant1;
          last_grant_d = grant1;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        nib_sum = {1'b0, a_q[{cnt_q, 2'b00} +: 4]}
                + {1'b0, b_q[{cnt_q, 2'b00} +: 4]}
                + {4'd0, carry_q};
        work_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d    = DONE;
          rsp_sum_d  = work_d;
          rsp_cout_d = nib_sum[4];
          rsp_id_d   = id_q;
          cnt_d      = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      id_q         <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      carry_q      <= carry_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      work_q       <= work_d;
      id_q         <= id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Directed bench for nibble_add_scheduler (WIDTH=16).
module tb_nibble_add_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_sub;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_sum;

  int total = 0;
  int bad   = 0;

  nibble_add_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change at +1, outputs are sampled at +2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0; req1_sub = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_cout, busy} !== 4'b0 || rsp_sum !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got v=%b id=%b cout=%b busy=%b sum=%h want all 0",
                 c, rsp_valid, rsp_id, rsp_cout, busy, rsp_sum);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    step(); #1;
  endtask

  // One isolated op: checks busy/rsp_valid on every cycle T+1..T+6 and the
  // result in T+5. Operand A is scrambled right after the handshake.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [15:0] exp_sum,
                       input logic exp_cout, input string name);
    int guard;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
    #1;
    guard = 0;
    while (!(id ? req1_ready : req0_ready) && guard < 20) begin
      step(); #1; guard++;
    end
    total++;
    if (!(id ? req1_ready : req0_ready) || (id ? req0_ready : req1_ready)) begin
      bad++;
      $display("FAIL %s handshake got r0=%b r1=%b want only r%0d", name,
               req0_ready, req1_ready, id);
      return;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (id) req1_a = ~a; else req0_a = ~a;
    #1;
    for (int k = 1; k <= 5; k++) begin
      total++;
      if (busy !== 1'b1 || rsp_valid !== (k == 5)) begin
        bad++;
        $display("FAIL %s timing T+%0d got busy=%b v=%b want busy=1 v=%b", name, k,
                 busy, rsp_valid, (k == 5));
      end
      if (k == 5) begin
        total++;
        if (rsp_sum !== exp_sum || rsp_cout !== exp_cout || rsp_id !== id) begin
          bad++;
          $display("FAIL %s result got sum=%h cout=%b id=%b want sum=%h cout=%b id=%b",
                   name, rsp_sum, rsp_cout, rsp_id, exp_sum, exp_cout, id);
        end
      end
      step(); #1;
    end
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got busy=%b v=%b want 0 0", name, busy, rsp_valid);
    end
    // Result registers hold after the strobe.
    total++;
    if (rsp_sum !== exp_sum) begin
      bad++;
      $display("FAIL %s hold got sum=%h want %h", name, rsp_sum, exp_sum);
    end
  endtask

  task automatic test_add();
    do_op(1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, "add_basic");
  endtask

  task automatic test_sub();
    do_op(1'b0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, "sub_pos");
    do_op(1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, "sub_neg");
  endtask

  task automatic test_ripple();
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_ripple");
  endtask

  task automatic test_back_to_back();
    int hs_cyc[$];
    int hs_id[$];
    int rid[$];
    logic [15:0] rsum[$];
    int cyc;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0100; req1_b = 16'h0010; req1_sub = 1'b1;
    #1;
    cyc = 0;
    while (rid.size() < 4 && cyc < 60) begin
      total++;
      if (req0_ready && req1_ready) begin
        bad++;
        $display("FAIL b2b_both_ready cyc=%0d got r0=1 r1=1 want at most one", cyc);
      end
      if (req0_ready || req1_ready) begin
        hs_cyc.push_back(cyc);
        hs_id.push_back(req1_ready ? 1 : 0);
      end
      if (rsp_valid) begin
        rid.push_back(rsp_id ? 1 : 0);
        rsum.push_back(rsp_sum);
      end
      step();
      cyc++;
      if (hs_cyc.size() == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
    end
    total++;
    if (hs_cyc.size() != 4 || rid.size() != 4) begin
      bad++;
      $display("FAIL b2b_count got hs=%0d rsp=%0d want 4 4", hs_cyc.size(), rid.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (hs_id[i] != (i % 2) || rid[i] != (i % 2)) begin
        bad++;
        $display("FAIL b2b_order[%0d] got grant=%0d rsp_id=%0d want %0d", i, hs_id[i],
                 rid[i], i % 2);
      end
      total++;
      if (rsum[i] !== ((i % 2) ? 16'h00F0 : 16'h0003)) begin
        bad++;
        $display("FAIL b2b_sum[%0d] got %h want %h", i, rsum[i],
                 (i % 2) ? 16'h00F0 : 16'h0003);
      end
      if (i > 0) begin
        total++;
        if (hs_cyc[i] - hs_cyc[i-1] != 6) begin
          bad++;
          $display("FAIL b2b_gap[%0d] got %0d want 6", i, hs_cyc[i] - hs_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    req1_valid = 1'b1; req1_a = 16'h0055; req1_b = 16'h0011; req1_sub = 1'b0;
    #1;
    guard = 0;
    while (!req1_ready && guard < 20) begin step(); #1; guard++; end
    total++;
    if (!req1_ready) begin
      bad++;
      $display("FAIL mid_handshake got r1=%b want 1", req1_ready);
    end
    step();                 // T+1: first CALC cycle
    req1_valid = 1'b0;
    step();                 // T+2: second CALC cycle
    reset = 1'b1;
    step(); #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_sum !== 16'h0) begin
      bad++;
      $display("FAIL mid_abort got v=%b busy=%b sum=%h want 0 0 0", rsp_valid, busy, rsp_sum);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0) begin
        bad++;
        $display("FAIL mid_no_rsp cyc=%0d got v=%b sum=%h want 0 0", c, rsp_valid, rsp_sum);
      end
      step(); #1;
    end
    req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h000F; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0300; req1_b = 16'h0300; req1_sub = 1'b0;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_regrant got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_a = 16'hAAAA;
    #1;
    guard = 0;
    while (!rsp_valid && guard < 10) begin step(); #1; guard++; end
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 16'h00FF || rsp_id !== 1'b0 || rsp_cout !== 1'b0) begin
      bad++;
      $display("FAIL mid_latched got v=%b sum=%h id=%b cout=%b want v=1 sum=00ff id=0 cout=0",
               rsp_valid, rsp_sum, rsp_id, rsp_cout);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ripple();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
